// File: rtl/dsp_nco_sweep_ctrl.sv
// dsp_nco_sweep_ctrl: stepped-frequency sweep scheduler driving dsp_nco phi_inc/en.
module dsp_nco_sweep_ctrl #(
  parameter int PHI_WIDTH   = 32,
  parameter int DWELL_WIDTH = 16,
  parameter int STEP_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic [PHI_WIDTH-1:0]   phi_start,
  input  logic [PHI_WIDTH-1:0]   phi_step,
  input  logic [STEP_WIDTH-1:0]  step_count,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [PHI_WIDTH-1:0]   phi_inc,
  output logic                   nco_en,
  output logic                   busy,
  output logic                   step_stb,
  output logic                   wrap_stb,
  output logic                   done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 state;
  logic                   mode_q;
  logic [PHI_WIDTH-1:0]   start_q, step_q;
  logic [STEP_WIDTH-1:0]  n_q, idx;
  logic [DWELL_WIDTH-1:0] d_q, dcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      start_q  <= '0;
      step_q   <= '0;
      n_q      <= '0;
      d_q      <= '0;
      idx      <= '0;
      dcnt     <= '0;
      phi_inc  <= '0;
      nco_en   <= 1'b0;
      busy     <= 1'b0;
      step_stb <= 1'b0;
      wrap_stb <= 1'b0;
      done     <= 1'b0;
    end else begin
      step_stb <= 1'b0;
      wrap_stb <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE) begin
        if (start && !abort) begin
          state    <= RUN;
          mode_q   <= mode;
          start_q  <= phi_start;
          step_q   <= phi_step;
          n_q      <= step_count;
          d_q      <= dwell;
          idx      <= '0;
          dcnt     <= dwell;
          phi_inc  <= phi_start;
          nco_en   <= 1'b1;
          busy     <= 1'b1;
          step_stb <= 1'b1;
        end
      end else if (abort) begin
        state  <= IDLE;
        nco_en <= 1'b0;
        busy   <= 1'b0;
      end else if (dcnt != '0) begin
        dcnt <= dcnt - 1'b1;
      end else if (idx != n_q) begin
        phi_inc  <= phi_inc + step_q;
        idx      <= idx + 1'b1;
        dcnt     <= d_q;
        step_stb <= 1'b1;
      end else if (mode_q) begin
        phi_inc  <= start_q;
        idx      <= '0;
        dcnt     <= d_q;
        step_stb <= 1'b1;
        wrap_stb <= 1'b1;
      end else begin
        state  <= IDLE;
        nco_en <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dsp_nco_sweep_ctrl.sv
// tb_dsp_nco_sweep_ctrl: vector table, directed corner sequences and a randomized
// run against a cycle-index reference model of the sweep schedule.
module tb_dsp_nco_sweep_ctrl;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0, mode = 0;
  logic [31:0] phi_start = 0, phi_step = 0;
  logic [15:0] step_count = 0, dwell = 0;
  logic [31:0] phi_inc;
  logic        nco_en, busy, step_stb, wrap_stb, done;
  int          checks = 0, errors = 0;

  dsp_nco_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .phi_start(phi_start), .phi_step(phi_step), .step_count(step_count), .dwell(dwell),
    .phi_inc(phi_inc), .nco_en(nco_en), .busy(busy), .step_stb(step_stb),
    .wrap_stb(wrap_stb), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        start, abort, mode;
    logic [31:0] ps, pst;
    logic [15:0] n, d;
    logic [31:0] e_phi;
    logic        e_en, e_stb, e_wrap, e_done;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic s, logic a, logic m, logic [31:0] ps, logic [31:0] pst,
                              logic [15:0] n, logic [15:0] d, logic [31:0] ph,
                              logic en, logic stb, logic wr, logic dn);
    vec_t v;
    v.start = s; v.abort = a; v.mode = m; v.ps = ps; v.pst = pst; v.n = n; v.d = d;
    v.e_phi = ph; v.e_en = en; v.e_stb = stb; v.e_wrap = wr; v.e_done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic m, input logic [31:0] ps, input logic [31:0] pst,
                     input logic [15:0] n, input logic [15:0] d);
    mode = m; phi_start = ps; phi_step = pst; step_count = n; dwell = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: position within the sweep is a plain cycle index since start.
  logic        m_run, m_mode, m_en, m_stb, m_wrap, m_done;
  logic [31:0] m_ps, m_pst, m_phi;
  logic [15:0] m_n, m_d;
  longint      m_t;

  task automatic model_eval();
    longint per, u, k;
    per = (longint'(m_n) + 1) * (longint'(m_d) + 1);
    u = m_mode ? m_t % per : m_t;
    k = u / (longint'(m_d) + 1);
    m_phi = m_ps + m_pst * 32'(k);
    m_stb = (u % (longint'(m_d) + 1)) == 0;
    m_wrap = m_mode && u == 0 && m_t != 0;
    m_en = 1'b1;
  endtask

  task automatic model_step();
    longint per;
    m_stb = 0; m_wrap = 0; m_done = 0;
    if (!m_run) begin
      if (start && !abort) begin
        m_run = 1; m_t = 0; m_mode = mode; m_ps = phi_start; m_pst = phi_step;
        m_n = step_count; m_d = dwell;
        model_eval();
      end
    end else if (abort) begin
      m_run = 0; m_en = 0;
    end else begin
      m_t++;
      per = (longint'(m_n) + 1) * (longint'(m_d) + 1);
      if (!m_mode && m_t == per) begin
        m_run = 0; m_en = 0; m_done = 1;
      end else model_eval();
    end
  endtask

  initial begin
    logic seen;
    // single sweep 1000/250, N=3, D=2
    tv.push_back(mk(1, 0, 0, 1000, 250, 3, 2, 1000, 1, 1, 0, 0));
    for (int j = 1; j < 12; j++)
      tv.push_back(mk(0, 0, 0, 1000, 250, 3, 2, 32'(1000 + 250 * (j / 3)), 1, j % 3 == 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1000, 250, 3, 2, 1750, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1000, 250, 3, 2, 1750, 0, 0, 0, 0));
    // modular wrap-around of the tuning word
    tv.push_back(mk(1, 0, 0, 32'hFFFF_FF00, 32'h200, 1, 0, 32'hFFFF_FF00, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 32'hFFFF_FF00, 32'h200, 1, 0, 32'h0000_0100, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 32'hFFFF_FF00, 32'h200, 1, 0, 32'h0000_0100, 0, 0, 0, 1));
    // start together with abort is dropped
    tv.push_back(mk(1, 1, 0, 5, 1, 0, 0, 32'h100, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 5, 1, 0, 0, 32'h100, 0, 0, 0, 0));
    // N=0, D=0 single, then restart on the done cycle
    tv.push_back(mk(1, 0, 0, 77, 9, 0, 0, 77, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 77, 9, 0, 0, 77, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 0, 500, 9, 0, 0, 500, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 500, 9, 0, 0, 500, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 500, 9, 0, 0, 500, 0, 0, 0, 0));

    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {phi_inc, nco_en, busy, step_stb, wrap_stb, done}, 37'd0);
    @(negedge clk);
    rst_n = 1;
    #1;

    foreach (tv[i]) begin
      start = tv[i].start; abort = tv[i].abort;
      cfg(tv[i].mode, tv[i].ps, tv[i].pst, tv[i].n, tv[i].d);
      cyc();
      chk($sformatf("vec%0d phi", i), phi_inc, tv[i].e_phi);
      chk($sformatf("vec%0d ctl", i), {nco_en, busy, step_stb, wrap_stb, done},
          {tv[i].e_en, tv[i].e_en, tv[i].e_stb, tv[i].e_wrap, tv[i].e_done});
    end
    start = 0; abort = 0;

    // continuous sweep: 12-cycle period, wrap on reload, never done
    cfg(1, 1000, 250, 3, 2);
    start = 1;
    cyc();
    start = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) cyc();
      chk($sformatf("cont%0d", c), {phi_inc, nco_en, step_stb, wrap_stb, done},
          {32'(1000 + 250 * ((c % 12) / 3)), 1'b1, c % 3 == 0, c > 0 && c % 12 == 0, 1'b0});
    end
    abort = 1;
    cyc();
    abort = 0;
    chk("cont abort en", {nco_en, busy}, 2'b00);

    // abort mid-dwell at step 2
    cfg(0, 1000, 250, 3, 2);
    start = 1;
    cyc();
    start = 0;
    repeat (7) cyc();
    chk("abort pre phi", phi_inc, 1500);
    abort = 1;
    cyc();
    abort = 0;
    chk("abort post", {phi_inc, nco_en, busy, step_stb, wrap_stb, done}, {32'd1500, 5'b0});
    seen = 0;
    repeat (12) begin
      cyc();
      seen |= done | nco_en;
    end
    chk("abort no done", seen, 0);

    // start while busy is ignored
    cfg(0, 1000, 250, 3, 2);
    start = 1;
    cyc();
    start = 0;
    cyc();
    cfg(1, 9999, 1, 0, 0);
    start = 1;
    cyc();
    start = 0;
    cyc();
    chk("busy start phi", phi_inc, 1250);
    repeat (9) cyc();
    chk("busy start done", {phi_inc, done, nco_en}, {32'd1750, 2'b10});

    // asynchronous reset mid-sweep
    cfg(0, 1000, 250, 3, 2);
    start = 1;
    cyc();
    start = 0;
    repeat (4) cyc();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("async reset", {phi_inc, nco_en, busy, step_stb, wrap_stb, done}, 37'd0);
    @(negedge clk);
    rst_n = 1;
    start = 1;
    cyc();
    start = 0;
    chk("post reset start", {phi_inc, nco_en, busy, step_stb}, {32'd1000, 3'b111});

    // randomized run against the reference model
    rst_n = 0;
    cyc();
    rst_n = 1;
    m_run = 0; m_mode = 0; m_en = 0; m_stb = 0; m_wrap = 0; m_done = 0;
    m_phi = 0; m_ps = 0; m_pst = 0; m_n = 0; m_d = 0; m_t = 0;
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 29) == 0;
      cfg($urandom_range(0, 1), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
          16'($urandom_range(0, 4)), 16'($urandom_range(0, 3)));
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rand%0d", i), {phi_inc, nco_en, busy, step_stb, wrap_stb, done},
          {m_phi, m_en, m_en, m_stb, m_wrap, m_done});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_nco_sweep_ctrl.md
# dsp_nco_sweep_ctrl

Stepped-frequency sweep scheduler for `dsp_nco`. It drives the NCO's `phi_inc` and `en` inputs to step the tuning word from a start value by a fixed increment, holding each frequency for a programmable dwell. It supports a single sweep or a continuous repeating sweep, and can be aborted at any time. It sits between the host or register interface and `dsp_nco` in the same clock domain.

## Interface
Parameters:
- `PHI_WIDTH`, 32, tuning-word width; must match `dsp_nco.PHI_WIDTH`.
- `DWELL_WIDTH`, 16, width of the dwell counter.
- `STEP_WIDTH`, 16, width of the step counter.

Ports:
- `clk`  in  1  system clock (the NCO sample clock).
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  level; forces IDLE; has priority over everything else.
- `mode`  in  1  0 = single sweep, 1 = continuous (restart at `phi_start` after the last step).
- `phi_start`  in  PHI_WIDTH  first tuning word.
- `phi_step`  in  PHI_WIDTH  increment added per step (modulo 2^PHI_WIDTH).
- `step_count`  in  STEP_WIDTH  N; the sweep visits N+1 frequencies.
- `dwell`  in  DWELL_WIDTH  D; each frequency is held D+1 cycles.
- `phi_inc`  out  PHI_WIDTH  tuning word to `dsp_nco.phi_inc`.
- `nco_en`  out  1  to `dsp_nco.en`.
- `busy`  out  1  high in RUN.
- `step_stb`  out  1  one-cycle pulse on every `phi_inc` change while running (including the first value).
- `wrap_stb`  out  1  one-cycle pulse when continuous mode reloads `phi_start`.
- `done`  out  1  one-cycle pulse on normal completion of a single sweep.

## Operation
- All outputs are registered. Reset values: `phi_inc`=0, `nco_en`=0, `busy`=0, `step_stb`=0, `wrap_stb`=0, `done`=0, state=IDLE, counters=0.
- `mode`, `phi_start`, `phi_step`, `step_count` and `dwell` are latched on accepted `start`. Input changes during RUN have no effect.
- Two states:
  - IDLE -> RUN on `start` && !`abort`.
  - RUN -> IDLE on `abort`, or at the end of the last dwell when latched mode=0.
- Entering RUN:
  - `phi_inc`<=`phi_start`, `nco_en`<=1, `busy`<=1, `step_stb`<=1.
  - dwell_cnt<=D, step_idx<=0.
- RUN, each cycle with dwell_cnt≠0: dwell_cnt decrements; all outputs hold.
- RUN, dwell_cnt==0 and step_idx<N: `phi_inc`<=`phi_inc`+`phi_step`, truncated to PHI_WIDTH (wrap-around is legal); step_idx++, dwell_cnt<=D, `step_stb`<=1.
- RUN, dwell_cnt==0 and step_idx==N:
  - mode=1: `phi_inc`<=`phi_start`, step_idx<=0, dwell_cnt<=D, `step_stb`<=1, `wrap_stb`<=1.
  - mode=0: go to IDLE; `nco_en`<=0, `busy`<=0, `done`<=1.
- `abort` in RUN: next cycle IDLE, `nco_en`=0, `busy`=0. No `done`, `step_stb` or `wrap_stb` pulse.
- `abort` in IDLE: no effect. `start` and `abort` in the same cycle: `start` is dropped.
- `start` while busy: ignored, no queueing.
- `phi_inc` holds its last value in IDLE; only reset clears it.
- Boundary cases:
  - D=0: a new word every cycle.
  - N=0: one frequency. In mode 0 it is held D+1 cycles, then `done`. In mode 1 it is held forever, with `step_stb`/`wrap_stb` pulsing every D+1 cycles.
  - `phi_step`=0: the word stays constant, but the sequencing is unchanged.
- Reset asserted mid-sweep: all outputs return to their reset values immediately (asynchronous).

## Timing
- `start` sampled high at edge T:
  - T+1: `busy`=`nco_en`=1, `phi_inc`=`phi_start`, `step_stb`=1.
- Frequency k (0..N) is presented in cycles T+1+k(D+1) through T+k(D+1)+D+1.
- Single sweep:
  - at T+1+(N+1)(D+1): `nco_en`=0, `busy`=0, `done`=1 for one cycle.
  - total enabled cycles: (N+1)(D+1).
- `start` is accepted again on the cycle `done` is high; the new RUN begins the following cycle.
- `abort` sampled at edge A: `nco_en`=0 at A+1.
- `step_stb` is coincident with the first cycle of each new `phi_inc` value.

## Test plan
- Single sweep: reset, then `start` with `phi_start`=1000, `phi_step`=250, N=3, D=2, mode=0 -> `phi_inc` 1000,1250,1500,1750, each for 3 cycles. `nco_en` is high for 12 cycles, 4 `step_stb` pulses, `done` at T+13, no `wrap_stb`.
- Continuous: same configuration with mode=1 -> after 1750, `phi_inc`=1000 with `wrap_stb`. Over 30 cycles the period is 12 cycles and `done` never fires.
- Wrap-around: `phi_start`=0xFFFF_FF00, `phi_step`=0x200, N=1, D=0 -> `phi_inc` 0xFFFF_FF00 then 0x0000_0100, `done` at T+3.
- Abort: mid-dwell at step 2 of the single sweep -> `nco_en`/`busy` low next cycle, `phi_inc` holds 1500, no `done`. Then `start` and `abort` in the same cycle -> stays IDLE.
- Ignored start / degenerate config: `start` pulsed while busy changes nothing. N=0, D=0, mode=0 -> one cycle of `nco_en` then `done`.
- Async reset: `rst_n` dropped mid-sweep (between clock edges) -> all outputs 0 immediately. Release, then `start` -> normal sweep from `phi_start`.
